// File: rtl/lcd_power_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// lcd_seq_pkg
//   Shared definitions for the LCD power sequencer:
//   - lcd_state_e : sequencer state encoding (also the debug port encoding)
//   - DEF_*_DELAY : default delay constants (cycles at 50 MHz)
//   - max3        : helper used to size the shared countdown timer
// ---------------------------------------------------------------------------
package lcd_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_PWR_WAIT = 3'd1,
    ST_ON       = 3'd2,
    ST_BL_WAIT  = 3'd3,
    ST_OFF_WAIT = 3'd4
  } lcd_state_e;

  localparam int unsigned DEF_PWR_DELAY = 32'd50000;
  localparam int unsigned DEF_BL_DELAY  = 32'd10000;
  localparam int unsigned DEF_OFF_DELAY = 32'd100000;

  // Largest of three delays; one timer is shared by all timed states.
  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/lcd_power_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_power_sequencer_if
//   Request/status bundle between the LCD_ON PIO side and the sequencer.
//   Signals:
//     lcd_on_req : request level from software (PIO out_port)
//     lcd_on     : panel power enable
//     lcd_blon   : backlight enable
//     ready      : panel fully on
//     busy       : sequencer in a timed transition
//   Modports:
//     master : PIO/firmware side (drives request, observes status)
//     slave  : sequencer side (consumes request, drives enables/status)
// ---------------------------------------------------------------------------
interface lcd_power_sequencer_if;
  logic lcd_on_req;
  logic lcd_on;
  logic lcd_blon;
  logic ready;
  logic busy;

  modport master (
    output lcd_on_req,
    input  lcd_on,
    input  lcd_blon,
    input  ready,
    input  busy
  );

  modport slave (
    input  lcd_on_req,
    output lcd_on,
    output lcd_blon,
    output ready,
    output busy
  );
endinterface

// File: rtl/lcd_power_sequencer_timer.sv
// ---------------------------------------------------------------------------
// lcd_seq_timer
//   Loadable down-counter that saturates at zero (never wraps).
//   Ports:
//     clk      : system clock
//     reset_n  : asynchronous active-low reset (count -> 0)
//     load     : load load_val this cycle (takes priority over counting)
//     load_val : value to load
//     value    : current count
//     zero     : count is zero
// ---------------------------------------------------------------------------
module lcd_seq_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins, otherwise decrement until zero and hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != {WIDTH{1'b0}}) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;
  assign zero  = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_power_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_power_sequencer
//   Turns the software LCD enable level into a timed panel power sequence:
//   power-up settle before backlight, backlight-off lead before power-off,
//   and a minimum off time before the panel may be re-powered.
//   Parameters:
//     PWR_DELAY : cycles from lcd_on rising to lcd_blon rising (>= 1)
//     BL_DELAY  : cycles from lcd_blon falling to lcd_on falling (>= 1)
//     OFF_DELAY : minimum cycles lcd_on stays low before re-power (>= 1)
//   Ports:
//     clk       : system clock
//     reset_n   : asynchronous active-low reset
//     bus       : lcd_power_sequencer_if.slave (req in; lcd_on, lcd_blon,
//                 ready, busy out -- all registered)
//     state_dbg : [2:0] registered state encoding, only when the macro
//                 LCD_SEQ_DEBUG_EN is defined
// ---------------------------------------------------------------------------
module lcd_power_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int unsigned PWR_DELAY = DEF_PWR_DELAY,
  parameter int unsigned BL_DELAY  = DEF_BL_DELAY,
  parameter int unsigned OFF_DELAY = DEF_OFF_DELAY
) (
  input  logic clk,
  input  logic reset_n,
  lcd_power_sequencer_if.slave bus
`ifdef LCD_SEQ_DEBUG_EN
  ,
  output logic [2:0] state_dbg
`endif
);

  localparam int unsigned MAX_DELAY = max3(PWR_DELAY, BL_DELAY, OFF_DELAY);
  localparam int unsigned TW        = $clog2(MAX_DELAY + 32'd1);

  // The timer reaches zero after delay-1 decrements, so the state change
  // lands exactly `delay` cycles after entry.
  localparam logic [TW-1:0] PWR_LOAD = TW'(PWR_DELAY - 32'd1);
  localparam logic [TW-1:0] BL_LOAD  = TW'(BL_DELAY - 32'd1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_DELAY - 32'd1);

  lcd_state_e    state_q;
  lcd_state_e    state_d;
  logic          lcd_on_q;
  logic          lcd_on_d;
  logic          lcd_blon_q;
  logic          lcd_blon_d;
  logic          ready_q;
  logic          ready_d;
  logic          busy_q;
  logic          busy_d;

  logic          tmr_load_s;
  logic [TW-1:0] tmr_load_val_s;
  logic [TW-1:0] tmr_value_s;
  logic          tmr_zero_s;
  logic          tmr_unused_s;

  lcd_seq_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load_s),
    .load_val (tmr_load_val_s),
    .value    (tmr_value_s),
    .zero     (tmr_zero_s)
  );

  // The FSM only needs the zero flag; the count itself is not consumed.
  assign tmr_unused_s = ^tmr_value_s;

  // Next-state, timer load and output decode (outputs follow next state so
  // they are registered alongside it).
  always_comb begin
    state_d        = state_q;
    tmr_load_s     = 1'b0;
    tmr_load_val_s = {TW{1'b0}};
    case (state_q)
      ST_OFF: begin
        if (bus.lcd_on_req) begin
          state_d        = ST_PWR_WAIT;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = PWR_LOAD;
        end else begin
          state_d = ST_OFF;
        end
      end
      ST_PWR_WAIT: begin
        // Abort has priority: the backlight must never light if the
        // request vanishes during settle.
        if (!bus.lcd_on_req) begin
          state_d        = ST_OFF_WAIT;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = OFF_LOAD;
        end else if (tmr_zero_s) begin
          state_d = ST_ON;
        end else begin
          state_d = ST_PWR_WAIT;
        end
      end
      ST_ON: begin
        if (!bus.lcd_on_req) begin
          state_d        = ST_BL_WAIT;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = BL_LOAD;
        end else begin
          state_d = ST_ON;
        end
      end
      ST_BL_WAIT: begin
        // Request is ignored here; the power-down always completes.
        if (tmr_zero_s) begin
          state_d        = ST_OFF_WAIT;
          tmr_load_s     = 1'b1;
          tmr_load_val_s = OFF_LOAD;
        end else begin
          state_d = ST_BL_WAIT;
        end
      end
      ST_OFF_WAIT: begin
        if (tmr_zero_s) begin
          state_d = ST_OFF;
        end else begin
          state_d = ST_OFF_WAIT;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase

    lcd_on_d   = 1'b0;
    lcd_blon_d = 1'b0;
    ready_d    = 1'b0;
    busy_d     = 1'b0;
    case (state_d)
      ST_OFF: begin
        lcd_on_d = 1'b0;
      end
      ST_PWR_WAIT: begin
        lcd_on_d = 1'b1;
        busy_d   = 1'b1;
      end
      ST_ON: begin
        lcd_on_d   = 1'b1;
        lcd_blon_d = 1'b1;
        ready_d    = 1'b1;
      end
      ST_BL_WAIT: begin
        lcd_on_d = 1'b1;
        busy_d   = 1'b1;
      end
      ST_OFF_WAIT: begin
        busy_d = 1'b1;
      end
      default: begin
        lcd_on_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops both enables immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_OFF;
      lcd_on_q   <= 1'b0;
      lcd_blon_q <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lcd_on_q   <= lcd_on_d;
      lcd_blon_q <= lcd_blon_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.lcd_on   = lcd_on_q;
  assign bus.lcd_blon = lcd_blon_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;

`ifdef LCD_SEQ_DEBUG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_power_sequencer
//   Bench for lcd_power_sequencer with PWR_DELAY=4, BL_DELAY=2, OFF_DELAY=3.
//   A cycle model pushes expected outputs for every driven request; a
//   negedge monitor pops and compares. Scenario tasks add timing checks.
// ---------------------------------------------------------------------------
module tb_lcd_power_sequencer;

  localparam int P = 4;
  localparam int B = 2;
  localparam int O = 3;

  typedef struct packed {
    logic       on;
    logic       blon;
    logic       ready;
    logic       busy;
    logic [2:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lcd_power_sequencer_if bus();

`ifdef LCD_SEQ_DEBUG_EN
  logic [2:0] state_dbg;
`endif

  lcd_power_sequencer #(
    .PWR_DELAY (P),
    .BL_DELAY  (B),
    .OFF_DELAY (O)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
`ifdef LCD_SEQ_DEBUG_EN
    ,
    .state_dbg (state_dbg)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model: m_cnt counts edges spent in the current state.
  int m_st  = 0;
  int m_cnt = 0;

  task automatic model_edge(input logic req);
    case (m_st)
      0: if (req) begin m_st = 1; m_cnt = 0; end
      1: begin
        if (!req) begin m_st = 4; m_cnt = 0; end
        else if (m_cnt == P - 1) begin m_st = 2; m_cnt = 0; end
        else m_cnt++;
      end
      2: if (!req) begin m_st = 3; m_cnt = 0; end
      3: begin
        if (m_cnt == B - 1) begin m_st = 4; m_cnt = 0; end
        else m_cnt++;
      end
      4: begin
        if (m_cnt == O - 1) begin m_st = 0; m_cnt = 0; end
        else m_cnt++;
      end
      default: m_st = 0;
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.on    = (m_st == 1) || (m_st == 2) || (m_st == 3);
    e.blon  = (m_st == 2);
    e.ready = (m_st == 2);
    e.busy  = (m_st == 1) || (m_st == 3) || (m_st == 4);
    e.st    = 3'(m_st);
    return e;
  endfunction

  // Drive one request level for one clock, queueing the expected outputs.
  task automatic drive_req(input logic req);
    bus.lcd_on_req = req;
    model_edge(req);
    sb_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare registered outputs half a cycle after the edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      total++;
      if ({bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy} !==
          {mon_e.on, mon_e.blon, mon_e.ready, mon_e.busy}) begin
        bad++;
        $display("FAIL sb_outputs t=%0t: got on=%b blon=%b ready=%b busy=%b, expected on=%b blon=%b ready=%b busy=%b",
                 $time, bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy,
                 mon_e.on, mon_e.blon, mon_e.ready, mon_e.busy);
      end
`ifdef LCD_SEQ_DEBUG_EN
      total++;
      if (state_dbg !== mon_e.st) begin
        bad++;
        $display("FAIL sb_state_dbg t=%0t: got %0d expected %0d", $time, state_dbg, mon_e.st);
      end
`endif
    end
  end

  task automatic test_reset();
    bus.lcd_on_req = 1'b0;
    reset_n = 1'b0;
    #2;
    total++;
    if ({bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy});
    end
    bus.lcd_on_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold: got %b expected 0000",
               {bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy});
    end
    bus.lcd_on_req = 1'b0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    m_st = 0;
    m_cnt = 0;
  endtask

  task automatic test_power_up();
    int rise_at = -1;
    drive_req(1'b1);
    total++;
    if (bus.lcd_on !== 1'b1 || bus.busy !== 1'b1 || bus.lcd_blon !== 1'b0) begin
      bad++;
      $display("FAIL pwr_on_edge: got on=%b busy=%b blon=%b expected 1 1 0",
               bus.lcd_on, bus.busy, bus.lcd_blon);
    end
    for (int i = 1; i <= P + 3; i++) begin
      drive_req(1'b1);
      if (rise_at < 0 && bus.lcd_blon === 1'b1) rise_at = i;
    end
    total++;
    if (rise_at != P) begin
      bad++;
      $display("FAIL blon_delay: got %0d cycles expected %0d", rise_at, P);
    end
    total++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL on_status: got ready=%b busy=%b expected 1 0", bus.ready, bus.busy);
    end
  endtask

  task automatic test_power_down();
    int fall_at = -1;
    int off_at  = -1;
    drive_req(1'b0);
    total++;
    if ({bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy} !== 4'b1001) begin
      bad++;
      $display("FAIL bl_off_edge: got on,blon,ready,busy=%b expected 1001",
               {bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy});
    end
    for (int i = 1; i <= B + O + 3; i++) begin
      drive_req(1'b0);
      if (fall_at < 0 && bus.lcd_on === 1'b0) fall_at = i;
      if (off_at < 0 && bus.busy === 1'b0) off_at = i;
    end
    total++;
    if (fall_at != B) begin
      bad++;
      $display("FAIL on_fall_delay: got %0d expected %0d", fall_at, B);
    end
    total++;
    if (off_at != B + O) begin
      bad++;
      $display("FAIL off_wait_len: got %0d expected %0d", off_at, B + O);
    end
  endtask

  task automatic test_abort();
    int rise_at = -1;
    bit blon_seen = 1'b0;
    drive_req(1'b1);
    drive_req(1'b1);
    drive_req(1'b0);
    total++;
    if ({bus.lcd_on, bus.lcd_blon, bus.busy} !== 3'b001) begin
      bad++;
      $display("FAIL abort_edge: got on,blon,busy=%b expected 001",
               {bus.lcd_on, bus.lcd_blon, bus.busy});
    end
    for (int i = 1; i <= O + 3; i++) begin
      drive_req(1'b1);
      if (bus.lcd_blon === 1'b1) blon_seen = 1'b1;
      if (rise_at < 0 && bus.lcd_on === 1'b1) rise_at = i;
    end
    total++;
    if (rise_at != O + 1) begin
      bad++;
      $display("FAIL abort_repower: got %0d expected %0d", rise_at, O + 1);
    end
    total++;
    if (blon_seen !== 1'b0) begin
      bad++;
      $display("FAIL abort_blon: got %b expected 0", blon_seen);
    end
    for (int i = 0; i <= O; i++) drive_req(1'b0);
  endtask

  task automatic test_bl_toggle();
    int low = 1;
    for (int i = 0; i <= P; i++) drive_req(1'b1);
    drive_req(1'b0);
    drive_req(1'b1);
    total++;
    if (bus.lcd_blon !== 1'b0 || bus.lcd_on !== 1'b1) begin
      bad++;
      $display("FAIL bl_ignore_req: got blon=%b on=%b expected 0 1", bus.lcd_blon, bus.lcd_on);
    end
    drive_req(1'b1);
    total++;
    if (bus.lcd_on !== 1'b0) begin
      bad++;
      $display("FAIL bl_fall: got on=%b expected 0", bus.lcd_on);
    end
    for (int i = 0; i < O + 4; i++) begin
      drive_req(1'b1);
      if (bus.lcd_on === 1'b0) low++;
      else break;
    end
    total++;
    if (low != O + 1) begin
      bad++;
      $display("FAIL low_time: got %0d expected %0d", low, O + 1);
    end
  endtask

  task automatic test_async_reset();
    int rise_at = -1;
    for (int i = 0; i < P; i++) drive_req(1'b1);
    total++;
    if (bus.ready !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_on: got ready=%b expected 1", bus.ready);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if ({bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy} !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset: got %b expected 0000",
               {bus.lcd_on, bus.lcd_blon, bus.ready, bus.busy});
    end
    m_st = 0;
    m_cnt = 0;
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    drive_req(1'b1);
    total++;
    if (bus.lcd_on !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_on: got %b expected 1", bus.lcd_on);
    end
    for (int i = 1; i <= P + 1; i++) begin
      drive_req(1'b1);
      if (rise_at < 0 && bus.lcd_blon === 1'b1) rise_at = i;
    end
    total++;
    if (rise_at != P) begin
      bad++;
      $display("FAIL post_reset_blon: got %0d expected %0d", rise_at, P);
    end
  endtask

  task automatic test_random();
    logic req = 1'b1;
    logic prev_on;
    int   low_run = 0;
    prev_on = bus.lcd_on;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) req = ~req;
      drive_req(req);
      total++;
      if (bus.lcd_blon === 1'b1 && bus.lcd_on !== 1'b1) begin
        bad++;
        $display("FAIL inv_blon_on t=%0t: blon=%b on=%b", $time, bus.lcd_blon, bus.lcd_on);
      end
      total++;
      if (bus.ready === 1'b1 && bus.busy === 1'b1) begin
        bad++;
        $display("FAIL inv_ready_busy t=%0t: ready=%b busy=%b", $time, bus.ready, bus.busy);
      end
      if (bus.lcd_on === 1'b1 && prev_on === 1'b0) begin
        total++;
        if (low_run < O) begin
          bad++;
          $display("FAIL off_gap t=%0t: got %0d expected >= %0d", $time, low_run, O);
        end
      end
      if (bus.lcd_on === 1'b0) low_run++;
      else low_run = 0;
      prev_on = bus.lcd_on;
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_abort();
    test_bl_toggle();
    test_async_reset();
    test_random();
    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
